// File: rtl/ram_clear_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_clear_dp : simple-dual-port RAM with lane write enables, a registered   |
// | read port and a hardware clear sweep after every reset.                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ram_clear_dp #(
  parameter int addressWidth = 6,
  parameter int dataWidth    = 32,
  parameter int dataDepth    = 48,
  parameter int laneWidth    = 8,
  parameter int bypass       = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           busy,
  input  logic                           wrSelect,
  input  logic [addressWidth-1:0]        wrAddress,
  input  logic [dataWidth-1:0]           wrData,
  input  logic [dataWidth/laneWidth-1:0] wrEnable,
  input  logic                           rdSelect,
  input  logic [addressWidth-1:0]        rdAddress,
  output logic [dataWidth-1:0]           rdData,
  output logic                           rdValid,
  output logic                           rdError,
  output logic                           wrError
);

  localparam int                      LANES     = dataWidth / laneWidth;
  localparam logic [addressWidth:0]   DEPTH     = (addressWidth + 1)'(dataDepth);
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(dataDepth - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [addressWidth-1:0] clear_addr_q, clear_addr_d;
  logic [dataWidth-1:0]    rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_error_q, rd_error_d;
  logic                    wr_error_q, wr_error_d;

  logic [dataWidth-1:0]    mem [0:dataDepth-1];

  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    wr_hit;
  logic [dataWidth-1:0]    wr_mask;
  logic [dataWidth-1:0]    wr_merged;
  logic [dataWidth-1:0]    rd_word;
  logic                    mem_we;
  logic [addressWidth-1:0] mem_waddr;
  logic [dataWidth-1:0]    mem_wdata;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign wr_mask[g*laneWidth +: laneWidth] = {laneWidth{wrEnable[g]}};
  end

  assign wr_in_range = {1'b0, wrAddress} < DEPTH;
  assign rd_in_range = {1'b0, rdAddress} < DEPTH;
  assign wr_hit      = wrSelect && wr_in_range && (wrAddress == rdAddress);
  assign wr_merged   = (mem[wrAddress] & ~wr_mask) | (wrData & wr_mask);

  // Same-address read sees the merged word only when bypass is enabled.
  assign rd_word = ((bypass != 0) && wr_hit) ? wr_merged : mem[rdAddress];

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    rd_error_d   = 1'b0;
    wr_error_d   = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wrAddress;
    mem_wdata    = wr_merged;
    case (state_q)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clear_addr_q;
        mem_wdata    = '0;
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        mem_we     = wrSelect && wr_in_range;
        wr_error_d = wrSelect && !wr_in_range;
        if (rdSelect) begin
          rd_valid_d = 1'b1;
          rd_error_d = !rd_in_range;
          rd_data_d  = rd_in_range ? rd_word : '0;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR;
      clear_addr_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_error_q   <= 1'b0;
      wr_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_error_q   <= rd_error_d;
      wr_error_q   <= wr_error_d;
    end
  end

  assign busy    = (state_q == CLEAR);
  assign rdData  = rd_data_q;
  assign rdValid = rd_valid_q;
  assign rdError = rd_error_q;
  assign wrError = wr_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_clear_dp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_clear_dp : scoreboard bench for ram_clear_dp, bypass=1 and bypass=0  |
// | instances driven with identical stimulus. Revision: 1.0                     |
// +----------------------------------------------------------------------------+
module tb_ram_clear_dp;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 48;
  localparam int LW    = 8;
  localparam int LANES = DW / LW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_sel, rd_sel;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [DW-1:0]    wr_data;
  logic [LANES-1:0] wr_en;

  logic          busy1, rv1, re1, we1;
  logic [DW-1:0] rd1;
  logic          busy0, rv0, re0, we0;
  logic [DW-1:0] rd0;

  ram_clear_dp #(.addressWidth(AW), .dataWidth(DW), .dataDepth(DEPTH),
                 .laneWidth(LW), .bypass(1)) dut_byp (
    .clock(clk), .reset(rst), .busy(busy1),
    .wrSelect(wr_sel), .wrAddress(wr_addr), .wrData(wr_data), .wrEnable(wr_en),
    .rdSelect(rd_sel), .rdAddress(rd_addr),
    .rdData(rd1), .rdValid(rv1), .rdError(re1), .wrError(we1)
  );

  ram_clear_dp #(.addressWidth(AW), .dataWidth(DW), .dataDepth(DEPTH),
                 .laneWidth(LW), .bypass(0)) dut_nobyp (
    .clock(clk), .reset(rst), .busy(busy0),
    .wrSelect(wr_sel), .wrAddress(wr_addr), .wrData(wr_data), .wrEnable(wr_en),
    .rdSelect(rd_sel), .rdAddress(rd_addr),
    .rdData(rd0), .rdValid(rv0), .rdError(re0), .wrError(we0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    bit            rv;
    bit            re;
    bit            we;
    logic [DW-1:0] d1;
    logic [DW-1:0] d0;
  } exp_t;

  exp_t          q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  int            edge_cnt    = 0;
  int            sweep_left  = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] last0 = '0;

  always @(posedge clk) edge_cnt++;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [LANES-1:0] en);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < LANES; i++)
      if (en[i]) r[i*LW +: LW] = d[i*LW +: LW];
    return r;
  endfunction

  // Drive one request for the coming edge and record what it must produce.
  task automatic apply(input bit ws, input int wa, input logic [DW-1:0] wd,
                       input logic [LANES-1:0] we, input bit rs, input int ra);
    exp_t e;
    bit   wr_ok, rd_ok;
    wr_sel  = ws;  wr_addr = AW'(wa); wr_data = wd; wr_en = we;
    rd_sel  = rs;  rd_addr = AW'(ra);
    if (sweep_left > 0) begin
      sweep_left--;
      return;
    end
    wr_ok = ws && (wa < DEPTH);
    rd_ok = ra < DEPTH;
    e.due = edge_cnt + 1;
    e.rv  = rs;
    e.re  = rs && !rd_ok;
    e.we  = ws && !wr_ok;
    e.d1  = '0;
    e.d0  = '0;
    if (rs && rd_ok) begin
      e.d0 = model[ra];
      e.d1 = (wr_ok && wa == ra) ? merge(model[ra], wd, we) : model[ra];
    end
    if (e.rv || e.we) q.push_back(e);
    if (wr_ok) model[wa] = merge(model[wa], wd, we);
  endtask

  task automatic cycle(input bit ws, input int wa, input logic [DW-1:0] wd,
                       input logic [LANES-1:0] we, input bit rs, input int ra);
    apply(ws, wa, wd, we, rs, ra);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  task automatic readback_all();
    for (int a = 0; a < DEPTH; a++) cycle(1'b0, 0, '0, '0, 1'b1, a);
    idle();
  endtask

  // Called with reset already high: hold, release on a falling edge, run the sweep.
  task automatic reset_and_sweep();
    q.delete();
    last1 = '0;
    last0 = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    sweep_left = DEPTH;
    for (int k = 1; k <= DEPTH; k++) begin
      cycle(1'b1, int'($urandom_range(0, DEPTH - 1)), $urandom(), LANES'($urandom()),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
      check1("busy_sweep_byp", busy1, k < DEPTH);
      check1("busy_sweep_nobyp", busy0, k < DEPTH);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].due < edge_cnt) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missed_strobe: got none expected response due at edge %0d", e.due);
      end
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        e = q.pop_front();
        check1("rdValid_byp", rv1, e.rv);
        check1("rdValid_nobyp", rv0, e.rv);
        check1("rdError_byp", re1, e.re);
        check1("rdError_nobyp", re0, e.re);
        check1("wrError_byp", we1, e.we);
        check1("wrError_nobyp", we0, e.we);
        if (e.rv) begin
          last1 = e.d1;
          last0 = e.d0;
        end
      end else begin
        check1("idle_rdValid_byp", rv1, 1'b0);
        check1("idle_rdValid_nobyp", rv0, 1'b0);
        check1("idle_wrError_byp", we1, 1'b0);
        check1("idle_wrError_nobyp", we0, 1'b0);
      end
      check32("rdData_byp", rd1, last1);
      check32("rdData_nobyp", rd0, last0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_sel = 1'b0; wr_addr = '0; wr_data = '0; wr_en = '0;
    rd_sel = 1'b0; rd_addr = '0;
    #1 rst = 1'b1;
    #1;
    check1("reset_busy", busy1, 1'b1);
    check1("reset_rdValid", rv1, 1'b0);
    check1("reset_rdError", re1, 1'b0);
    check1("reset_wrError", we1, 1'b0);
    check32("reset_rdData", rd1, '0);
    check32("reset_rdData_nobyp", rd0, '0);
    reset_and_sweep();
    readback_all();

    cycle(1'b1, 5, 32'hAABBCCDD, 4'b1111, 1'b0, 0);
    cycle(1'b1, 5, 32'h11223344, 4'b0101, 1'b0, 0);
    cycle(1'b0, 0, '0, '0, 1'b1, 5);
    idle();
    idle();

    cycle(1'b1, 7, 32'h12345678, 4'b1111, 1'b0, 0);
    cycle(1'b1, 7, 32'hFFFFFFFF, 4'b0011, 1'b1, 7);
    cycle(1'b0, 0, '0, '0, 1'b1, 7);
    idle();

    cycle(1'b1, 50, 32'hDEADBEEF, 4'b1111, 1'b0, 0);
    idle();
    cycle(1'b0, 0, '0, '0, 1'b1, 63);
    idle();
    cycle(1'b1, 55, 32'hCAFEF00D, 4'b1111, 1'b1, 48);
    idle();
    readback_all();

    for (int a = 0; a < 10; a++) cycle(1'b0, 0, '0, '0, 1'b1, a);
    idle();

    for (int n = 0; n < 300; n++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom(),
            LANES'($urandom()), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                        : int'($urandom_range(0, 9)));
    end
    idle();

    apply(1'b0, 0, '0, '0, 1'b1, 60);
    @(posedge clk);
    #1;
    check1("pending_rdValid", rv1, 1'b1);
    check1("pending_rdError", re1, 1'b1);
    #1 rst = 1'b1;
    q.delete();
    #1;
    check1("async_rdValid_byp", rv1, 1'b0);
    check1("async_rdValid_nobyp", rv0, 1'b0);
    check1("async_rdError_byp", re1, 1'b0);
    check1("async_rdError_nobyp", re0, 1'b0);
    check1("async_busy_byp", busy1, 1'b1);
    check1("async_busy_nobyp", busy0, 1'b1);
    reset_and_sweep();
    readback_all();

    repeat (3) idle();
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d outstanding expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
